// File: rtl/sprite_table_writer_if.sv
// Avalon-MM slave bus bundle for sprite_table_writer.
//   chipselect/read/write : transfer qualifiers from the CPU side
//   address[4:0]          : word address
//   writedata[31:0]       : write payload
//   readdata[31:0]        : registered read data, one cycle after read
//   waitrequest           : stalls shadow writes while the table is being copied
interface sprite_table_writer_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/sprite_table_writer.sv
// Double-buffered sprite descriptor table behind an Avalon-MM slave.
// The CPU edits a shadow table; a commit request is applied at the next
// vertical blank by copying shadow -> active one entry per cycle, after which
// a level interrupt is raised. The active table feeds the line renderer.
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : Avalon-MM slave (sprite_table_writer_if.slave)
//   irq         : commit-done interrupt, cleared by CTRL bit1
//   VGA_VCOUNT  : current scan line
//   sprite_out  : active table, entry i at [24*i+23:24*i]
// Address map: 0..N-1 shadow (RW), 15 CTRL/STATUS, 16..16+N-1 active (RO).
module sprite_table_writer #(
  parameter int NUM_SPRITES = 3,
  parameter int VBLANK_LINE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  sprite_table_writer_if.slave     bus,
  output logic                     irq,
  input  logic [9:0]               VGA_VCOUNT,
  output logic [NUM_SPRITES*24-1:0] sprite_out
);
  localparam int         IDX_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [4:0] CTRL_ADDR = 5'd15;
  localparam logic [4:0] ACT_BASE  = 5'd16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_COPY    = 2'd2;

  logic [1:0]                   state;
  logic [IDX_W-1:0]             copy_idx;
  logic                         repend;
  logic [9:0]                   vcount_prev;
  logic [15:0]                  frame_count;
  logic [NUM_SPRITES-1:0][23:0] shadow;
  logic [NUM_SPRITES-1:0][23:0] active;

  logic                   wr_req, rd_req, ctrl_wr, commit_req, irq_clr;
  logic                   vblank_start, copying, last_step, shadow_wr;
  logic [NUM_SPRITES-1:0] sh_sel;
  logic [31:0]            status, rd_mux;
  logic                   unused_wd;

  // A read together with a write is treated as a write only.
  assign wr_req     = bus.chipselect & bus.write;
  assign rd_req     = bus.chipselect & bus.read & ~bus.write;
  assign ctrl_wr    = wr_req & (bus.address == CTRL_ADDR);
  assign commit_req = ctrl_wr & bus.writedata[0];
  assign irq_clr    = ctrl_wr & bus.writedata[1];

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sel
    assign sh_sel[i] = (bus.address == 5'(i));
  end

  assign copying   = (state == S_COPY);
  assign last_step = copying && (copy_idx == IDX_W'(NUM_SPRITES - 1));

  // Shadow writes are held off while the copy reads the shadow table, so
  // the committed snapshot is exactly what existed at vblank.
  assign bus.waitrequest = wr_req & (|sh_sel) & copying;
  assign shadow_wr       = wr_req & ~copying;

  assign vblank_start = (vcount_prev != 10'(VBLANK_LINE)) &&
                        (VGA_VCOUNT == 10'(VBLANK_LINE));

  assign status = {frame_count, 13'd0, irq, copying, (state == S_PENDING)};

  // Upper descriptor bits are not stored.
  assign unused_wd = ^bus.writedata[31:24];

  always_ff @(posedge clk) begin
    if (reset) begin
      vcount_prev <= '0;
      frame_count <= '0;
    end else begin
      vcount_prev <= VGA_VCOUNT;
      if (vblank_start) frame_count <= frame_count + 16'd1;
    end
  end

  // Request accepted in IDLE only moves to PENDING, so a vblank in that
  // same cycle is missed and the commit waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      copy_idx <= '0;
      repend   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (commit_req) state <= S_PENDING;
        S_PENDING: if (vblank_start) begin
          state    <= S_COPY;
          copy_idx <= '0;
          repend   <= 1'b0;
        end
        S_COPY: begin
          if (commit_req) repend <= 1'b1;
          if (last_step) begin
            state    <= (repend | commit_req) ? S_PENDING : S_IDLE;
            repend   <= 1'b0;
            copy_idx <= '0;
          end else begin
            copy_idx <= copy_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (shadow_wr && sh_sel[i]) shadow[i] <= bus.writedata[23:0];
        if (copying && (copy_idx == IDX_W'(i))) active[i] <= shadow[i];
      end
    end
  end

  // Completion takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)          irq <= 1'b0;
    else if (last_step) irq <= 1'b1;
    else if (irq_clr)   irq <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    if (bus.address == CTRL_ADDR) rd_mux = status;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (bus.address == 5'(i))            rd_mux = {8'h00, shadow[i]};
      if (bus.address == ACT_BASE + 5'(i)) rd_mux = {8'h00, active[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       bus.readdata <= '0;
    else if (rd_req) bus.readdata <= rd_mux;
  end

  assign sprite_out = active;
endmodule

// File: tb/tb_sprite_table_writer.sv
module tb_sprite_table_writer;
  localparam int N  = 3;
  localparam int VB = 480;
  localparam int STALL_LIMIT = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic            irq;
  logic [9:0]      vcount;
  logic [N*24-1:0] sprite_out;

  sprite_table_writer_if bus();

  sprite_table_writer #(.NUM_SPRITES(N), .VBLANK_LINE(VB)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .irq        (irq),
    .VGA_VCOUNT (vcount),
    .sprite_out (sprite_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  // Reference model: table contents and counters as the CPU sees them.
  logic [23:0] shadow_m [N];
  logic [23:0] active_m [N];
  logic [15:0] frame_m;
  logic        irq_m;
  logic        pend_m;

  function automatic logic [N*24-1:0] exp_sprites();
    logic [N*24-1:0] v;
    for (int i = 0; i < N; i++) v[24*i +: 24] = active_m[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_status(input logic busy);
    return {frame_m, 13'd0, irq_m, busy, pend_m};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = '0;
      active_m[i] = '0;
    end
    frame_m = '0;
    irq_m   = 1'b0;
    pend_m  = 1'b0;
  endtask

  // A commit that reached vblank publishes the whole shadow table.
  task automatic commit_done();
    for (int i = 0; i < N; i++) active_m[i] = shadow_m[i];
    irq_m  = 1'b1;
    pend_m = 1'b0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, output int stalls);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      stalls++;
      if (stalls > STALL_LIMIT) begin
        check("stall_bound", 128'(stalls), 128'(STALL_LIMIT));
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    tick(1);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
  endtask

  task automatic vblank();
    vcount = 10'(VB);
    tick(1);
    vcount = 10'd0;
    frame_m++;
  endtask

  initial begin
    logic [31:0] rd, hold, wd;
    int          s, e;
    logic        do_commit, do_clr;

    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    vcount         = 10'd0;
    reset          = 1'b1;
    model_reset();
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst_sprite", 128'(sprite_out), 128'(exp_sprites()));
    check("rst_irq", 128'(irq), 128'(irq_m));
    check("rst_wait", 128'(bus.waitrequest), 128'(0));
    check("rst_readdata", 128'(bus.readdata), 128'(0));
    bus_read(5'd15, rd);
    check("rst_status", 128'(rd), 128'(exp_status(1'b0)));

    // Shadow write/readback, upper byte dropped
    bus_write(5'd0, 32'h00A0_6450, s);
    shadow_m[0] = 24'hA06450;
    check("wr_nostall", 128'(s), 128'(0));
    bus_read(5'd0, rd);
    check("shadow0_rb", 128'(rd), 128'({8'h00, shadow_m[0]}));
    wr(5'd1, 32'hFF12_3456);
    shadow_m[1] = 24'h123456;
    bus_read(5'd1, rd);
    check("shadow1_mask", 128'(rd), 128'({8'h00, shadow_m[1]}));

    // Commit then vblank: N busy status reads, then idle with irq
    wr(5'd15, 32'h1);
    pend_m = 1'b1;
    bus_read(5'd15, rd);
    check("status_pending", 128'(rd), 128'(exp_status(1'b0)));
    vblank();
    pend_m = 1'b0;
    for (int k = 0; k < N; k++) begin
      bus_read(5'd15, rd);
      check("status_busy", 128'(rd), 128'(exp_status(1'b1)));
    end
    commit_done();
    bus_read(5'd15, rd);
    check("status_done", 128'(rd), 128'(exp_status(1'b0)));
    check("copy_sprite", 128'(sprite_out), 128'(exp_sprites()));
    check("copy_irq", 128'(irq), 128'(irq_m));
    bus_read(5'd16, rd);
    check("active0_rb", 128'(rd), 128'(32'h00A06450));

    // Shadow edit without commit: active unchanged across frames
    wr(5'd2, $urandom());
    wd = $urandom();
    wr(5'd2, wd);
    shadow_m[2] = wd[23:0];
    for (int f = 0; f < 3; f++) begin
      vblank();
      tick(N + 2);
      check("nocommit_sprite", 128'(sprite_out), 128'(exp_sprites()));
      bus_read(5'd15, rd);
      check("frame_count", 128'(rd), 128'(exp_status(1'b0)));
    end

    // Shadow write during COPY stalls exactly N cycles and is not committed
    wr(5'd15, 32'h1);
    pend_m = 1'b1;
    vblank();
    commit_done();
    wd = $urandom();
    bus_write(5'd0, wd, s);
    check("copy_stalls", 128'(s), 128'(N));
    check("copy_snapshot", 128'(sprite_out), 128'(exp_sprites()));
    shadow_m[0] = wd[23:0];
    bus_read(5'd0, rd);
    check("late_shadow_rb", 128'(rd), 128'({8'h00, shadow_m[0]}));
    bus_read(5'd16, rd);
    check("late_active_rb", 128'(rd), 128'({8'h00, active_m[0]}));

    // Commit during COPY re-arms: back to PENDING, next vblank copies again
    wr(5'd15, 32'h1);
    pend_m = 1'b1;
    vblank();
    wr(5'd15, 32'h1);
    tick(N);
    commit_done();
    pend_m = 1'b1;
    bus_read(5'd15, rd);
    check("repend_status", 128'(rd), 128'(exp_status(1'b0)));
    wd = $urandom();
    wr(5'd1, wd);
    shadow_m[1] = wd[23:0];
    vblank();
    tick(N + 1);
    commit_done();
    check("repend_sprite", 128'(sprite_out), 128'(exp_sprites()));

    // irq clear, then set/clear collision at the last copy step
    wr(5'd15, 32'h2);
    irq_m = 1'b0;
    check("irq_clear", 128'(irq), 128'(irq_m));
    wr(5'd15, 32'h1);
    pend_m = 1'b1;
    vblank();
    tick(N - 1);
    wr(5'd15, 32'h2);
    commit_done();
    check("irq_set_wins", 128'(irq), 128'(irq_m));
    wr(5'd15, 32'h2);
    irq_m = 1'b0;
    check("irq_clear2", 128'(irq), 128'(irq_m));

    // Commit accepted in the vblank_start cycle waits one frame
    wd = $urandom();
    wr(5'd2, wd);
    shadow_m[2] = wd[23:0];
    vcount = 10'(VB);
    wr(5'd15, 32'h1);
    vcount = 10'd0;
    frame_m++;
    pend_m = 1'b1;
    tick(N + 2);
    bus_read(5'd15, rd);
    check("vb_req_status", 128'(rd), 128'(exp_status(1'b0)));
    check("vb_req_nocopy", 128'(sprite_out), 128'(exp_sprites()));
    vblank();
    tick(N + 1);
    commit_done();
    check("vb_req_copy", 128'(sprite_out), 128'(exp_sprites()));

    // Unmapped addresses and read+write collision
    wr(5'd20, $urandom());
    bus_read(5'd20, rd);
    check("unmapped_rd", 128'(rd), 128'(0));
    bus_read(5'(16 + N), rd);
    check("unmapped_rd2", 128'(rd), 128'(0));
    for (int i = 0; i < N; i++) begin
      bus_read(5'(i), rd);
      check("unmapped_noeffect", 128'(rd), 128'({8'h00, shadow_m[i]}));
    end
    bus_read(5'd16, hold);
    wd = $urandom();
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 5'd1;
    bus.writedata  = wd;
    tick(1);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    shadow_m[1] = wd[23:0];
    check("rw_hold", 128'(bus.readdata), 128'(hold));
    bus_read(5'd1, rd);
    check("rw_write_wins", 128'(rd), 128'({8'h00, shadow_m[1]}));

    // Randomized frames against the model
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(1, 3)) begin
        e  = $urandom_range(0, N - 1);
        wd = $urandom();
        wr(5'(e), wd);
        shadow_m[e] = wd[23:0];
      end
      do_clr    = 1'($urandom_range(0, 1));
      do_commit = 1'($urandom_range(0, 1));
      if (do_clr) begin
        wr(5'd15, 32'h2);
        irq_m = 1'b0;
      end
      if (do_commit) begin
        wr(5'd15, 32'h1);
        pend_m = 1'b1;
      end
      vblank();
      tick(N + 1);
      if (do_commit) commit_done();
      check("rnd_sprite", 128'(sprite_out), 128'(exp_sprites()));
      check("rnd_irq", 128'(irq), 128'(irq_m));
      bus_read(5'd15, rd);
      check("rnd_status", 128'(rd), 128'(exp_status(1'b0)));
      e = $urandom_range(0, N - 1);
      bus_read(5'(16 + e), rd);
      check("rnd_active_rb", 128'(rd), 128'({8'h00, active_m[e]}));
    end

    // frame_count wrap: preload near the top, the path is otherwise 64k frames
    force dut.frame_count = 16'hFFFE;
    #1;
    release dut.frame_count;
    frame_m = 16'hFFFE;
    vblank();
    tick(1);
    bus_read(5'd15, rd);
    check("frame_ffff", 128'(rd), 128'(exp_status(1'b0)));
    vblank();
    tick(1);
    bus_read(5'd15, rd);
    check("frame_wrap", 128'(rd), 128'(exp_status(1'b0)));

    // Reset in the middle of a copy clears everything
    for (int i = 0; i < N; i++) wr(5'(i), $urandom() | 32'h1);
    wr(5'd15, 32'h1);
    vblank();
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    check("midcopy_rst_sprite", 128'(sprite_out), 128'(exp_sprites()));
    check("midcopy_rst_irq", 128'(irq), 128'(irq_m));
    bus_read(5'd15, rd);
    check("midcopy_rst_status", 128'(rd), 128'(exp_status(1'b0)));
    bus_read(5'd0, rd);
    check("midcopy_rst_shadow", 128'(rd), 128'({8'h00, shadow_m[0]}));
    tick(N + 2);
    check("midcopy_rst_settle", 128'(sprite_out), 128'(exp_sprites()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
